// File: rtl/stage_start_sequencer.sv
// Stage start sequencer: launches a chain of downstream stage FSMs one at a
// time. Each stage gets a registered one-hot start pulse and the sequencer
// waits for that stage's done rising edge before moving on. A sticky
// finished or error flag reports the outcome to the top-level controller.
module stage_start_sequencer #(
    parameter int NUM_STAGES     = 3,
    parameter int PULSE_WIDTH    = 1,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] done,
    output logic [NUM_STAGES-1:0] start,
    output logic                  busy,
    output logic                  finished,
    output logic                  error,
    output logic [SW-1:0]         active_stage
);

    // Pulse counter runs 0 .. PULSE_WIDTH-1; timeout counter runs 0 .. TIMEOUT_CYCLES-1.
    localparam int PCW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_reg;
    logic [NUM_STAGES-1:0] start_reg;
    logic [NUM_STAGES-1:0] done_q_reg;
    logic                  go_q_reg;
    logic                  capture_reg;
    logic                  busy_reg;
    logic                  finished_reg;
    logic                  error_reg;
    logic [SW-1:0]         stage_reg;
    logic [PCW-1:0]        pulse_cnt_reg;
    logic [TCW-1:0]        timeout_cnt_reg;

    logic                  go_edge;
    logic [NUM_STAGES-1:0] done_edge;
    logic [NUM_STAGES-1:0] stage_sel;
    logic                  done_active;
    logic                  last_stage;
    logic                  pulse_last;
    logic                  timeout_hit;
    logic                  advance;

    assign go_edge = go & ~go_q_reg;

    // Per-stage rising-edge detectors on the done levels.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_done_edge
            assign done_edge[gi] = done[gi] & ~done_q_reg[gi];
        end
    endgenerate

    // Only the edge belonging to the active stage matters; all others are masked.
    assign stage_sel   = NUM_STAGES'(1) << stage_reg;
    assign done_active = |(done_edge & stage_sel);
    assign last_stage  = (stage_reg == SW'(NUM_STAGES - 1));
    assign pulse_last  = (pulse_cnt_reg == PCW'(PULSE_WIDTH - 1));
    assign timeout_hit = (TIMEOUT_CYCLES > 0) &&
                         (timeout_cnt_reg == TCW'(TIMEOUT_CYCLES - 1));
    // An edge captured during the pulse counts as if it arrived in WAIT.
    assign advance     = done_active | capture_reg;

    // Sequencer FSM with registered start/busy/flag outputs; abort overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            start_reg       <= '0;
            done_q_reg      <= '0;
            go_q_reg        <= 1'b0;
            capture_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            finished_reg    <= 1'b0;
            error_reg       <= 1'b0;
            stage_reg       <= '0;
            pulse_cnt_reg   <= '0;
            timeout_cnt_reg <= '0;
        end else begin
            // Edge-detect history is kept up to date in every state.
            go_q_reg   <= go;
            done_q_reg <= done;

            if (abort) begin
                // Back to IDLE; the sticky flags are deliberately left alone.
                state_reg       <= S_IDLE;
                start_reg       <= '0;
                busy_reg        <= 1'b0;
                stage_reg       <= '0;
                capture_reg     <= 1'b0;
                pulse_cnt_reg   <= '0;
                timeout_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (go_edge) begin
                            state_reg       <= S_PULSE;
                            start_reg       <= NUM_STAGES'(1);
                            busy_reg        <= 1'b1;
                            finished_reg    <= 1'b0;
                            error_reg       <= 1'b0;
                            stage_reg       <= '0;
                            capture_reg     <= 1'b0;
                            pulse_cnt_reg   <= '0;
                            timeout_cnt_reg <= '0;
                        end
                    end
                    S_PULSE: begin
                        if (done_active) begin
                            capture_reg <= 1'b1;
                        end
                        if (pulse_last) begin
                            state_reg     <= S_WAIT;
                            start_reg     <= '0;
                            pulse_cnt_reg <= '0;
                        end else begin
                            pulse_cnt_reg <= pulse_cnt_reg + PCW'(1);
                        end
                    end
                    S_WAIT: begin
                        if (advance) begin
                            capture_reg     <= 1'b0;
                            timeout_cnt_reg <= '0;
                            if (last_stage) begin
                                state_reg    <= S_DONE;
                                busy_reg     <= 1'b0;
                                finished_reg <= 1'b1;
                            end else begin
                                state_reg     <= S_PULSE;
                                stage_reg     <= stage_reg + SW'(1);
                                start_reg     <= stage_sel << 1;
                                pulse_cnt_reg <= '0;
                            end
                        end else if (timeout_hit) begin
                            // active_stage keeps the index of the stage that stalled.
                            state_reg       <= S_ERR;
                            busy_reg        <= 1'b0;
                            error_reg       <= 1'b1;
                            timeout_cnt_reg <= '0;
                        end else if (TIMEOUT_CYCLES > 0) begin
                            timeout_cnt_reg <= timeout_cnt_reg + TCW'(1);
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        start_reg <= '0;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign start        = start_reg;
    assign busy         = busy_reg;
    assign finished     = finished_reg;
    assign error        = error_reg;
    assign active_stage = stage_reg;

endmodule

// File: tb/tb_stage_start_sequencer.sv
// Bench for stage_start_sequencer. Each run is planned open-loop: a timeline
// model derives, from the sequencing rules, the slot of every observable
// event (start rise/fall, busy rise/fall, flag change) and pushes them into a
// scoreboard queue. A separate monitor watches the outputs and pops/compares.
// Slot n is the interval after the n-th rising clock edge; inputs applied in
// slot n are sampled at edge n+1.
module tb_stage_start_sequencer;
    localparam int N    = 3;
    localparam int PW   = 2;
    localparam int TO   = 16;
    localparam int MAXS = 20000;

    localparam int EV_START = 0, EV_BRISE = 1, EV_END = 2, EV_BFALL = 3, EV_FLAG = 4;

    logic         clk = 1'b0;
    logic         reset, go, abort;
    logic [N-1:0] done;
    logic [N-1:0] start;
    logic         busy, finished, error;
    logic [1:0]   active_stage;

    stage_start_sequencer #(
        .NUM_STAGES(N), .PULSE_WIDTH(PW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .abort(abort), .done(done),
        .start(start), .busy(busy), .finished(finished), .error(error),
        .active_stage(active_stage)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int val;
        int slot;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  fails  = 0;
    int  model_flags = 0;   // 0 none, 1 error set, 2 finished set

    bit         go_a [MAXS];
    bit         ab_a [MAXS];
    bit         rst_a[MAXS];
    logic [N-1:0] dn_a[MAXS];

    function automatic ev_t mk(int k, int v, int s);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.slot = s;
        return e;
    endfunction

    function automatic string kname(int k);
        case (k)
            EV_START: return "start_rise";
            EV_BRISE: return "busy_rise";
            EV_END:   return "start_fall";
            EV_BFALL: return "busy_fall";
            default:  return "flag_change";
        endcase
    endfunction

    function automatic int first_idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    // ---------------- monitor ----------------
    bit           mon_en = 0;
    logic [N-1:0] p_start = '0;
    logic         p_busy  = 1'b0;
    logic [1:0]   p_flags = 2'b00;

    task automatic observe(int kind, int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_%s: got val=%0d at slot %0d, expected no event",
                     kname(kind), val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.slot != cyc)
                begin
                    fails++;
                    $display("FAIL %s: got %s val=%0d slot=%0d, expected %s val=%0d slot=%0d",
                             kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.slot);
                end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ($countones(start) > 1 || (start != '0 && !busy)) begin
                fails++;
                $display("FAIL start_onehot: got start=%b busy=%b at slot %0d, expected one-hot start only while busy",
                         start, busy, cyc);
            end
            if (start != '0 && start != p_start) observe(EV_START, first_idx(start) * 8 + int'(active_stage));
            if (busy && !p_busy)                 observe(EV_BRISE, int'(active_stage));
            if (start == '0 && p_start != '0)    observe(EV_END, 0);
            if (!busy && p_busy)                 observe(EV_BFALL, int'(finished) * 64 + int'(error) * 32 + int'(active_stage));
            if ({finished, error} != p_flags)    observe(EV_FLAG, int'(finished) * 64 + int'(error) * 32 + int'(active_stage));
            p_start = start;
            p_busy  = busy;
            p_flags = {finished, error};
        end
    end

    // ---------------- model + driver for one run ----------------
    // mode_sel: 0 random, 1 done 3 slots into WAIT, 2 stage-0 early done,
    //           3 stage-1 timeout, 4 done on the timeout boundary slot.
    // abort_sel: 0 none, 1 random abort, 2 abort in stage-1 WAIT,
    //            3 reset in PULSE, 4 abort together with stage-1 done edge.
    task automatic run(input int mode_sel, input int abort_sel);
        int  c, g, s, w, d, f, a, r, mode, r0, act;
        int  s_arr[N];
        int  d_arr[N];
        ev_t evs[$];
        ev_t kept[$];
        bit  pulse_on;

        c  = cyc;
        g  = c + 3 + int'($urandom_range(0, 4));
        s  = g + 1;
        f  = -1;
        r0 = 0;
        for (int i = 0; i < N; i++) begin
            s_arr[i] = MAXS;
            d_arr[i] = -1;
        end

        for (int k = 0; k < N; k++) begin
            s_arr[k] = s;
            evs.push_back(mk(EV_START, k * 8 + k, s));
            if (k == 0) begin
                evs.push_back(mk(EV_BRISE, 0, s));
                if (model_flags != 0) evs.push_back(mk(EV_FLAG, 0, s));
            end
            evs.push_back(mk(EV_END, 0, s + PW));
            w = s + PW;
            r = 3;
            case (mode_sel)
                0: begin
                    mode = int'($urandom_range(0, 9));
                    mode = (mode < 3) ? 0 : (mode < 9) ? 1 : 2;
                    r = ($urandom_range(0, 3) == 0) ? TO - 1 : int'($urandom_range(0, TO - 1));
                end
                2:       mode = 1 - int'(k == 0);
                3:       mode = (k == 1) ? 2 : 1;
                4: begin mode = 1; r = TO - 1; end
                default: mode = 1;
            endcase
            if (mode == 0) begin
                d = (mode_sel == 2) ? s + 1 : s + int'($urandom_range(0, PW - 1));
                d_arr[k] = d;
                s = w + 1;
            end else if (mode == 1) begin
                d = w + r;
                d_arr[k] = d;
                if (k == 0) r0 = r;
                s = d + 1;
            end else begin
                f = w + TO;
                evs.push_back(mk(EV_BFALL, 32 + k, f));
                evs.push_back(mk(EV_FLAG, 32 + k, f));
                break;
            end
        end
        if (f < 0) begin
            f = s;
            evs.push_back(mk(EV_BFALL, 64 + N - 1, f));
            evs.push_back(mk(EV_FLAG, 64 + N - 1, f));
        end

        a = -1;
        case (abort_sel)
            1: a = int'($urandom_range(g + 1, f - 1));
            2: a = s_arr[1] + PW + 1;
            3: a = g + 1;
            4: a = d_arr[1];
            default: a = -1;
        endcase

        if (a >= 0) begin
            pulse_on = 1'b0;
            foreach (evs[i]) begin
                if (evs[i].slot <= a) begin
                    kept.push_back(evs[i]);
                    if (evs[i].kind == EV_START) pulse_on = 1'b1;
                    if (evs[i].kind == EV_END)   pulse_on = 1'b0;
                end
            end
            if (pulse_on) kept.push_back(mk(EV_END, 0, a + 1));
            kept.push_back(mk(EV_BFALL, 0, a + 1));
            f = a + 1;
            model_flags = 0;
        end else begin
            kept = evs;
            model_flags = (d_arr[N-1] >= 0) ? 2 : 1;
        end
        foreach (kept[i]) exp_q.push_back(kept[i]);

        // Input schedule.
        go_a[g] = 1'b1;
        for (int x = g + 1; x < f; x++) go_a[x] = 1'($urandom_range(0, 1));
        if (abort_sel == 3) rst_a[a] = 1'b1;
        else if (a >= 0)    ab_a[a]  = 1'b1;
        for (int k = 0; k < N; k++)
            if (d_arr[k] >= 0 && (a < 0 || d_arr[k] <= a)) dn_a[d_arr[k]][k] = 1'b1;
        // done[0] held high across launch: must not count as stage 0's edge.
        if (a < 0 && r0 >= 2 && (mode_sel == 4 || $urandom_range(0, 2) == 0))
            for (int x = g - 2; x <= d_arr[0] - 2; x++) dn_a[x][0] = 1'b1;
        // Spurious edges on stages that are not active at that slot.
        for (int x = g + 1; x < f; x++) begin
            if ($urandom_range(0, 5) == 0) begin
                int j;
                j = int'($urandom_range(0, N - 1));
                act = 0;
                for (int k = 0; k < N; k++) if (s_arr[k] <= x) act = k;
                if ((j < act || (j > act && x <= s_arr[j] - 2)) && (a < 0 || x <= a))
                    dn_a[x][j] = 1'b1;
            end
        end

        while (cyc <= f) begin
            go    = go_a[cyc];
            abort = ab_a[cyc];
            reset = rst_a[cyc];
            done  = dn_a[cyc];
            @(negedge clk);
            if (abort_sel == 3 && cyc == a + 1) begin
                checks++;
                if (start != '0 || busy || finished || error || active_stage != 2'd0) begin
                    fails++;
                    $display("FAIL midrun_reset: got start=%b busy=%b fin=%b err=%b stage=%0d, expected all zero",
                             start, busy, finished, error, active_stage);
                end
            end
        end
        $display("run mode=%0d abort=%0d launch=%0d end=%0d", mode_sel, abort_sel, g, f);
    endtask

    initial begin
        reset = 1'b1;
        go    = 1'b0;
        abort = 1'b0;
        done  = '0;
        for (int i = 0; i < MAXS; i++) dn_a[i] = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (start != '0) begin fails++; $display("FAIL reset_start: got %b, expected 0", start); end
        checks++;
        if (busy) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++;
        if (finished || error) begin
            fails++; $display("FAIL reset_flags: got fin=%b err=%b, expected 0 0", finished, error);
        end
        checks++;
        if (active_stage != 2'd0) begin
            fails++; $display("FAIL reset_stage: got %0d, expected 0", active_stage);
        end
        reset  = 1'b0;
        mon_en = 1;

        run(1, 0);          // nominal
        run(2, 0);          // early done on stage 0
        run(3, 0);          // stage 1 times out
        run(1, 0);          // restart after error
        run(1, 2);          // abort in stage-1 WAIT
        run(1, 4);          // abort together with done edge
        run(4, 0);          // done on the timeout cycle, done[0] held at launch
        run(3, 0);
        for (int i = 0; i < 30; i++) run(0, ($urandom_range(0, 3) == 0) ? 1 : 0);
        run(1, 3);          // reset mid-PULSE
        run(1, 0);

        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_events: got %0d events never observed, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
